// File: rtl/ex_forward_hazard_unit_if.sv
// ID-stage to forwarding/hazard unit bundle.
// The ID stage drives the master side and the forwarding unit implements the slave side.
interface ex_forward_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  pipe_en;
    logic                  flush_id;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic [1:0]            ForwardA;
    logic [1:0]            ForwardB;
    logic                  stall_if_id;
    logic                  bubble_id_ex;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output pipe_en, flush_id, id_valid, id_rs, id_rt,
        output id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_mem_read,
        input  ForwardA, ForwardB, stall_if_id, bubble_id_ex, stall_count
    );

    modport slave (
        input  pipe_en, flush_id, id_valid, id_rs, id_rt,
        input  id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_mem_read,
        output ForwardA, ForwardB, stall_if_id, bubble_id_ex, stall_count
    );
endinterface

// File: rtl/ex_forward_hazard_unit.sv
// EX-stage operand forwarding select generator with load-use stall control.
// Forward codes and stall counter are registered; stall/bubble are combinational.
module ex_forward_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    ex_forward_hazard_unit_if.slave bus
);
    typedef enum logic {RUN, LU_STALL} state_t;

    state_t                state;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [CNT_W-1:0]      count;

    logic       rs_ex, rt_ex, rs_mem, rt_mem;
    logic       hazard, stall, bubble;
    logic [1:0] next_a, next_b;

    function automatic logic [1:0] sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex)       sel = 2'b10;
        else if (hit_mem) sel = 2'b01;
        else              sel = 2'b00;
    endfunction

    // Source-versus-slot matching, load-use hazard and next forward codes.
    always_comb begin
        rs_ex  = bus.id_uses_rs && (bus.id_rs != '0) && ex_valid
                 && ex_reg_write && (ex_rd == bus.id_rs);
        rt_ex  = bus.id_uses_rt && (bus.id_rt != '0) && ex_valid
                 && ex_reg_write && (ex_rd == bus.id_rt);
        rs_mem = bus.id_uses_rs && (bus.id_rs != '0) && mem_valid
                 && mem_reg_write && (mem_rd == bus.id_rs);
        rt_mem = bus.id_uses_rt && (bus.id_rt != '0) && mem_valid
                 && mem_reg_write && (mem_rd == bus.id_rt);
        hazard = bus.id_valid && ex_valid && ex_mem_read && (rs_ex || rt_ex);
        stall  = bus.pipe_en && !bus.flush_id && hazard && (state == RUN);
        bubble = bus.pipe_en && (bus.flush_id || stall);
        next_a = sel(rs_ex, rs_mem);
        next_b = sel(rt_ex, rt_mem);
    end

    // Shadow slots, forward codes, stall FSM and counter advance with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            fwd_a         <= 2'b00;
            fwd_b         <= 2'b00;
            count         <= '0;
        end else if (bus.pipe_en) begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            if (bubble) begin
                ex_valid <= 1'b0;
                fwd_a    <= 2'b00;
                fwd_b    <= 2'b00;
            end else begin
                ex_valid     <= bus.id_valid;
                ex_rd        <= bus.id_rd;
                ex_reg_write <= bus.id_reg_write;
                ex_mem_read  <= bus.id_mem_read;
                fwd_a        <= next_a;
                fwd_b        <= next_b;
            end
            // The load reaches MEM during the stall, so one cycle always suffices.
            unique case (state)
                RUN:      state <= stall ? LU_STALL : RUN;
                LU_STALL: state <= RUN;
                default:  state <= RUN;
            endcase
            if (stall && (count != '1))
                count <= count + 1'b1;
        end
    end

    assign bus.ForwardA     = fwd_a;
    assign bus.ForwardB     = fwd_b;
    assign bus.stall_if_id  = stall;
    assign bus.bubble_id_ex = bubble;
    assign bus.stall_count  = count;
endmodule

// File: tb/tb_ex_forward_hazard_unit.sv
// Directed self-checking bench for ex_forward_hazard_unit.
// Inputs change on the falling edge; outputs are sampled 1 time unit after changes/edges.
module tb_ex_forward_hazard_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    ex_forward_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();

    ex_forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic mr);
        @(negedge clk);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rs   = urs;
        bus.id_uses_rt   = urt;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.pipe_en = 1'b1;
        bus.flush_id = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_rs = '0;
        bus.id_rt = '0;
        bus.id_uses_rs = 1'b0;
        bus.id_uses_rt = 1'b0;
        bus.id_rd = '0;
        bus.id_reg_write = 1'b0;
        bus.id_mem_read = 1'b0;

        #12;
        chk("rst_fa", bus.ForwardA, 2'b00);
        chk("rst_fb", bus.ForwardB, 2'b00);
        chk("rst_cnt", bus.stall_count, 16'd0);
        chk("rst_stall", bus.stall_if_id, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$5
        put(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        put(1, 3, 5, 1, 1, 4, 1, 0);
        chk("t1_stall", bus.stall_if_id, 1'b0);
        tick();
        chk("t1_fa", bus.ForwardA, 2'b10);
        chk("t1_fb", bus.ForwardB, 2'b00);

        // add $3 ; nop ; or $6,$7,$3
        put(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        put(1, 7, 3, 1, 1, 6, 1, 0);
        tick();
        chk("t2_fa", bus.ForwardA, 2'b00);
        chk("t2_fb", bus.ForwardB, 2'b01);

        // lw $8,0($1) ; add $9,$8,$8
        put(1, 1, 0, 1, 0, 8, 1, 1);
        tick();
        put(1, 8, 8, 1, 1, 9, 1, 0);
        chk("t3_stall", bus.stall_if_id, 1'b1);
        chk("t3_bubble", bus.bubble_id_ex, 1'b1);
        tick();
        chk("t3_cnt", bus.stall_count, 16'd1);
        chk("t3_fa_bub", bus.ForwardA, 2'b00);
        chk("t3_stall2", bus.stall_if_id, 1'b0);
        chk("t3_bubble2", bus.bubble_id_ex, 1'b0);
        tick();
        chk("t3_fa", bus.ForwardA, 2'b01);
        chk("t3_fb", bus.ForwardB, 2'b01);
        chk("t3_cnt2", bus.stall_count, 16'd1);

        // add $3 ; sub $3 ; and $5,$3,$3
        put(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        put(1, 4, 5, 1, 1, 3, 1, 0);
        tick();
        put(1, 3, 3, 1, 1, 5, 1, 0);
        tick();
        chk("t4_fa", bus.ForwardA, 2'b10);
        chk("t4_fb", bus.ForwardB, 2'b10);

        // write $0 then read $0
        put(1, 1, 0, 1, 0, 0, 1, 0);
        tick();
        put(1, 0, 0, 1, 1, 0, 0, 0);
        tick();
        chk("t4_z_fa", bus.ForwardA, 2'b00);
        chk("t4_z_fb", bus.ForwardB, 2'b00);

        // lw $8 ; beq $8,$8 with flush
        put(1, 1, 0, 1, 0, 8, 1, 1);
        tick();
        put(1, 8, 8, 1, 1, 0, 0, 0);
        bus.flush_id = 1'b1;
        #1;
        chk("t5_stall", bus.stall_if_id, 1'b0);
        chk("t5_bubble", bus.bubble_id_ex, 1'b1);
        tick();
        chk("t5_fa", bus.ForwardA, 2'b00);
        chk("t5_fb", bus.ForwardB, 2'b00);
        chk("t5_cnt", bus.stall_count, 16'd1);
        @(negedge clk);
        bus.flush_id = 1'b0;

        // add $1 ; lw $8,0($1) ; add $9,$8,$8 with pipe_en low
        put(1, 2, 3, 1, 1, 1, 1, 0);
        tick();
        put(1, 1, 0, 1, 0, 8, 1, 1);
        tick();
        chk("t6_fa_lw", bus.ForwardA, 2'b10);
        put(1, 8, 8, 1, 1, 9, 1, 0);
        bus.pipe_en = 1'b0;
        #1;
        chk("t6_stall_frz", bus.stall_if_id, 1'b0);
        chk("t6_bubble_frz", bus.bubble_id_ex, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_fa_frz", bus.ForwardA, 2'b10);
            chk("t6_cnt_frz", bus.stall_count, 16'd1);
        end
        @(negedge clk);
        bus.pipe_en = 1'b1;
        #1;
        chk("t6_stall", bus.stall_if_id, 1'b1);
        chk("t6_bubble", bus.bubble_id_ex, 1'b1);
        tick();
        chk("t6_cnt", bus.stall_count, 16'd2);

        // asynchronous reset while in LU_STALL
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_fa", bus.ForwardA, 2'b00);
        chk("t7_fb", bus.ForwardB, 2'b00);
        chk("t7_cnt", bus.stall_count, 16'd0);
        chk("t7_stall", bus.stall_if_id, 1'b0);
        chk("t7_bubble", bus.bubble_id_ex, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        put(1, 8, 8, 1, 1, 9, 1, 0);
        chk("t7_nostall", bus.bubble_id_ex, 1'b0);
        tick();
        chk("t7_fa2", bus.ForwardA, 2'b00);

        // FSM back in RUN: a fresh load-use must stall
        put(1, 1, 0, 1, 0, 8, 1, 1);
        tick();
        put(1, 8, 0, 1, 0, 9, 1, 0);
        chk("t7_restall", bus.stall_if_id, 1'b1);
        tick();
        chk("t7_cnt2", bus.stall_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ex_forward_hazard_unit.md
Name: ex_forward_hazard_unit

Overview:
- Producer side of the EX-stage operand forwarding interface: generates the registered ForwardA/ForwardB select codes consumed by the execute-stage ALU block, plus load-use stall and bubble controls.
- Keeps its own shadow copy of destination-register info for the EX and MEM stages, advancing with the pipeline.
- Computes forwarding for the instruction in ID and registers it so the codes are valid while that instruction is in EX.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pipe_en  input  1  global pipeline advance; 0 freezes all state.
- flush_id  input  1  taken branch/jump: the ID instruction must not enter EX.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_ADDR_W  source register A of ID instruction.
- id_rt  input  REG_ADDR_W  source register B of ID instruction.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt (R-type, sw, beq).
- id_rd  input  REG_ADDR_W  resolved destination register of ID instruction.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- ForwardA  output  2  EX operand A select: 10 = EX/MEM ALU result, 01 = MEM/WB write-back data, 00 = register file.
- ForwardB  output  2  same encoding for operand B and store data.
- stall_if_id  output  1  hold PC and IF/ID this cycle.
- bubble_id_ex  output  1  ID/EX loads a NOP this cycle.
- stall_count  output  CNT_W  number of load-use stall cycles taken, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): ForwardA = ForwardB = 00, all shadow valids 0, FSM = RUN, stall_count = 0.
- Shadow state:
  - EX slot holds {valid, rd, reg_write, mem_read}.
  - MEM slot holds {valid, rd, reg_write}.
- Source match rules:
  - A source matches a slot when: the "uses" bit is set, the source register is nonzero, and the slot has valid = 1, reg_write = 1 and rd equal to that source register.
  - Register $0 never matches.
- Load-use hazard (combinational): id_valid & EX.valid & EX.mem_read & (rs matches EX | rt matches EX).
- stall_if_id = pipe_en & ~flush_id & hazard & (state == RUN). flush_id has priority over stall.
- bubble_id_ex = pipe_en & (flush_id | stall_if_id).
- Next forward code, computed per operand:
  - If the source matches EX: 10 (the EX producer reaches EX/MEM by the time the consumer is in EX).
  - Else if the source matches MEM: 01.
  - Else: 00.
  - EX priority over MEM gives youngest-producer-wins.
- Rising edge with pipe_en = 1:
  - MEM slot <- EX slot (mem_read dropped).
  - If bubble_id_ex: EX.valid <- 0 and ForwardA/B <- 00.
  - Otherwise: EX slot <- {id_valid, id_rd, id_reg_write, id_mem_read} and ForwardA/B <- next codes.
- Rising edge with pipe_en = 0: every register holds, and stall_if_id and bubble_id_ex are forced to 0.
- FSM:
  - RUN -> LU_STALL on an edge where stall_if_id = 1.
  - LU_STALL -> RUN on the next pipe_en edge, unconditionally.
  - In LU_STALL the EX slot is a bubble, so the load has moved to MEM. The retried ID instruction gets 01 and the stall never exceeds one cycle per load.
  - flush_id in LU_STALL still returns the FSM to RUN.
- Forwarding from a load's MEM/WB stage carries loaded data, because the top level feeds the final write-back value to the MEM/WB forward input. A load in EX is never forwarded with 10, because stall precedes it.
- Same-cycle WB-to-ID read is not handled here; the register file provides write-before-read.
- stall_count increments by 1 on each edge where stall_if_id = 1 and holds at all-ones.
- Reset asserted mid-stall: the FSM returns to RUN and the shadows are cleared immediately. There is no pending bubble after release.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 (rs=3): ForwardA = 10 and ForwardB = 00 in the sub's EX cycle; no stall.
- add $3,… ; nop ; or $6,$7,$3 (rt=3): ForwardB = 01 in the or's EX cycle.
- lw $8,0($1) then add $9,$8,$8: stall_if_id = 1 and bubble_id_ex = 1 for exactly one cycle; the add then sees ForwardA = ForwardB = 01; stall_count 0 -> 1.
- Double producer: add $3,… ; sub $3,… ; and $5,$3,$3: ForwardA = ForwardB = 10 (youngest wins). Writes to $0 followed by reads of $0 always give 00.
- lw $8 then beq using $8 with flush_id = 1 in the same cycle: stall_if_id = 0, bubble_id_ex = 1; the next cycle's codes are 00; stall_count unchanged.
- pipe_en = 0 for 3 cycles during a hazard: outputs and shadows frozen, stall_if_id = 0, count frozen. Separately, drive rst_n low during LU_STALL: ForwardA/B = 00 and state = RUN asynchronously.
